psum_ofifo: RTL and testbench

- Output buffer directly downstream of the MAC array's bottom row.
- Captures each column's out_s partial sum when that column's valid strobe fires; columns arrive skewed in time.
- Presents a column-aligned row of psums to the SFU/memory write path once every column holds at least one entry.
- One independent circular FIFO per column, common pop.

---
 rtl/psum_ofifo_if.sv | 50 +++++
 rtl/psum_ofifo.sv | 108 ++++++++++
 tb/tb_psum_ofifo.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/psum_ofifo_if.sv
// psum_ofifo_if
//   Bundles the data/strobe/status signals between the MAC array output
//   stage and the psum output FIFO. Clock and reset stay outside the
//   interface as plain ports.
//
//   Signals (names as seen by the FIFO):
//     in       col*psum_bw  column psums, lane i = in[i*psum_bw +: psum_bw]
//     wr       col          per-lane write strobe
//     rd       1            pop request for all lanes
//     err_clr  1            synchronous clear of the sticky error flags
//     out      col*psum_bw  head row, same lane packing as in
//     o_valid  1            every lane non-empty
//     o_full   1            any lane full
//     o_ready  1            no lane full
//     err_ovf  1            sticky: write dropped on a full lane
//     err_udf  1            sticky: rd seen while o_valid low
//
//   Handshake: a lane accepts a write on a rising edge when wr[i] is high
//   and the lane is not full, or when it is full but a pop happens on the
//   same edge. A pop takes effect on a rising edge when rd and o_valid are
//   both high; out is valid (first-word-fall-through) whenever o_valid is
//   high, and is driven to zero otherwise.
//
//   master: the producer/consumer side (array + SFU path, or a testbench).
//   slave : the FIFO itself.
interface psum_ofifo_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16
);
  logic [col*psum_bw-1:0] in;
  logic [col-1:0]         wr;
  logic                   rd;
  logic                   err_clr;
  logic [col*psum_bw-1:0] out;
  logic                   o_valid;
  logic                   o_full;
  logic                   o_ready;
  logic                   err_ovf;
  logic                   err_udf;

  modport master (
    output in, wr, rd, err_clr,
    input  out, o_valid, o_full, o_ready, err_ovf, err_udf
  );

  modport slave (
    input  in, wr, rd, err_clr,
    output out, o_valid, o_full, o_ready, err_ovf, err_udf
  );
endinterface

// File: rtl/psum_ofifo.sv
// psum_ofifo
//   Output buffer sitting directly under the bottom row of the MAC array.
//   Each column has its own circular FIFO, written when that column's valid
//   strobe fires, so the skewed arrival of columns is absorbed here. A row
//   is presented downstream only once every column holds at least one
//   entry, and a single pop advances every lane together.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low reset (clears pointers and errors)
//     bus    psum_ofifo_if.slave (in, wr, rd, err_clr, out, o_valid,
//            o_full, o_ready, err_ovf, err_udf)
//
//   Parameters:
//     col      number of array columns / FIFO lanes
//     psum_bw  width of one partial sum
//     depth    entries per lane, power of two, >= 2
module psum_ofifo #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input logic         clk,
  input logic         reset,
  psum_ofifo_if.slave bus
);

  localparam int aw = $clog2(depth);

  // Per-lane status, assembled from the generate loop below.
  logic [col-1:0]         lane_empty;
  logic [col-1:0]         lane_full;
  logic [col-1:0]         wr_ok;
  logic [col*psum_bw-1:0] head;

  logic valid_int;
  logic full_int;
  logic pop;
  logic ovf_evt;
  logic udf_evt;

  assign valid_int = ~|lane_empty;
  assign full_int  = |lane_full;

  // A pop only happens when every lane has data; rd otherwise is an error.
  assign pop = bus.rd & valid_int;

  // A full lane still takes a write when the same edge pops it: the slot
  // being written is exactly the head slot that is leaving.
  assign wr_ok = bus.wr & (~lane_full | {col{pop}});

  assign ovf_evt = |(bus.wr & lane_full & ~{col{pop}});
  assign udf_evt = bus.rd & ~valid_int;

  for (genvar i = 0; i < col; i++) begin : g_lane
    logic [psum_bw-1:0] mem [depth];
    logic [aw:0]        wptr;
    logic [aw:0]        rptr;

    // One extra pointer bit distinguishes full from empty.
    assign lane_empty[i] = (wptr == rptr);
    assign lane_full[i]  = (wptr[aw-1:0] == rptr[aw-1:0]) &&
                           (wptr[aw] != rptr[aw]);

    assign head[i*psum_bw +: psum_bw] = mem[rptr[aw-1:0]];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_ok[i]) wptr <= wptr + 1'b1;
        if (pop)      rptr <= rptr + 1'b1;
      end
    end

    // Storage needs no reset; the pointers define what is live.
    always_ff @(posedge clk) begin
      if (wr_ok[i]) mem[wptr[aw-1:0]] <= bus.in[i*psum_bw +: psum_bw];
    end
  end

  // Sticky error flags: a new error in the clear cycle keeps the flag set.
  logic err_ovf_q;
  logic err_udf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      if (ovf_evt)          err_ovf_q <= 1'b1;
      else if (bus.err_clr) err_ovf_q <= 1'b0;

      if (udf_evt)          err_udf_q <= 1'b1;
      else if (bus.err_clr) err_udf_q <= 1'b0;
    end
  end

  // Head row is masked to zero while any lane is still empty.
  assign bus.out     = valid_int ? head : '0;
  assign bus.o_valid = valid_int;
  assign bus.o_full  = full_int;
  assign bus.o_ready = ~full_int;
  assign bus.err_ovf = err_ovf_q;
  assign bus.err_udf = err_udf_q;

endmodule

// File: tb/tb_psum_ofifo.sv
// tb_psum_ofifo
//   Directed self-checking bench for psum_ofifo (col=8, psum_bw=16,
//   depth=64). Inputs change on the falling edge; outputs are sampled on
//   the falling edge, half a cycle away from the active rising edge.
module tb_psum_ofifo;

  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 64;
  localparam int W     = COL * BW;

  logic clk;
  logic reset;

  psum_ofifo_if #(.col(COL), .psum_bw(BW)) bus ();

  psum_ofifo #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.wr      = '0;
    bus.rd      = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  // Each lane = {hi, lane index}.
  function automatic logic [W-1:0] mk_row(input logic [7:0] hi);
    logic [W-1:0] r;
    for (int l = 0; l < COL; l++) r[l*BW +: BW] = {hi, 8'(l)};
    return r;
  endfunction

  // Every lane carries the same value.
  function automatic logic [W-1:0] rep_row(input logic [BW-1:0] v);
    logic [W-1:0] r;
    for (int l = 0; l < COL; l++) r[l*BW +: BW] = v;
    return r;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] skew_row;
    logic [W-1:0] exp_row;
    int t;

    reset  = 1'b0;
    bus.in = '0;
    idle_inputs();
    repeat (2) step();
    reset = 1'b1;
    step();

    // Reset state.
    check("rst_out", bus.out, '0);
    check("rst_valid", W'(bus.o_valid), W'(0));
    check("rst_ready", W'(bus.o_ready), W'(1));
    check("rst_full", W'(bus.o_full), W'(0));
    check("rst_ovf", W'(bus.err_ovf), W'(0));
    check("rst_udf", W'(bus.err_udf), W'(0));

    // Skewed fill: lane i written at cycle i with 0x0100+i.
    for (int l = 0; l < COL; l++) skew_row[l*BW +: BW] = 16'h0100 + 16'(l);
    bus.in = skew_row;
    for (int i = 0; i < COL; i++) begin
      bus.wr = COL'(1) << i;
      step();
      check($sformatf("skew_valid_%0d", i), W'(bus.o_valid),
            W'((i == COL - 1) ? 1 : 0));
    end
    bus.wr = '0;
    check("skew_out", bus.out, skew_row);
    bus.rd = 1'b1;
    step();
    bus.rd = 1'b0;
    check("skew_pop_valid", W'(bus.o_valid), W'(0));
    check("skew_pop_out", bus.out, '0);
    check("skew_pop_udf", W'(bus.err_udf), W'(0));

    // Fill every lane to depth.
    bus.wr = '1;
    for (int r = 0; r < DEPTH; r++) begin
      bus.in = mk_row(8'(r));
      step();
    end
    bus.wr = '0;
    check("full_full", W'(bus.o_full), W'(1));
    check("full_ready", W'(bus.o_ready), W'(0));
    check("full_head", bus.out, mk_row(8'd0));

    // Write on full without pop is dropped.
    bus.wr = '1;
    bus.in = mk_row(8'h99);
    step();
    bus.wr = '0;
    check("ovf_flag", W'(bus.err_ovf), W'(1));
    check("ovf_head", bus.out, mk_row(8'd0));
    check("ovf_full", W'(bus.o_full), W'(1));
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    check("ovf_clr", W'(bus.err_ovf), W'(0));

    // Write on full with pop is accepted.
    bus.wr = '1;
    bus.rd = 1'b1;
    bus.in = mk_row(8'd64);
    step();
    idle_inputs();
    check("wrpop_full", W'(bus.o_full), W'(1));
    check("wrpop_ovf", W'(bus.err_ovf), W'(0));

    // Drain rows 1..64; the last one is the row written during the pop.
    for (int r = 1; r <= DEPTH; r++) begin
      check($sformatf("drain_%0d", r), bus.out, mk_row(8'(r)));
      bus.rd = 1'b1;
      step();
      bus.rd = 1'b0;
    end
    check("drain_valid", W'(bus.o_valid), W'(0));
    check("drain_udf", W'(bus.err_udf), W'(0));

    // Underflow.
    bus.rd = 1'b1;
    step();
    bus.rd = 1'b0;
    check("udf_flag", W'(bus.err_udf), W'(1));
    check("udf_valid", W'(bus.o_valid), W'(0));
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    check("udf_clr", W'(bus.err_udf), W'(0));

    // New underflow in the clear cycle keeps the flag.
    bus.rd      = 1'b1;
    bus.err_clr = 1'b1;
    step();
    idle_inputs();
    check("udf_clr_wins", W'(bus.err_udf), W'(1));
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;

    // Write into empty lanes with rd while invalid: write kept, pop ignored.
    bus.wr = '1;
    bus.rd = 1'b1;
    bus.in = rep_row(16'h5a5a);
    step();
    idle_inputs();
    check("wr_rd_empty_out", bus.out, rep_row(16'h5a5a));
    check("wr_rd_empty_udf", W'(bus.err_udf), W'(1));
    bus.rd      = 1'b1;
    bus.err_clr = 1'b1;
    step();
    idle_inputs();
    check("wr_rd_empty_drain", W'(bus.o_valid), W'(0));
    check("wr_rd_empty_clr", W'(bus.err_udf), W'(0));

    // Wrap-around stream: row k written at cycle k, popped at cycle k+3.
    for (t = 0; t < 203; t++) begin
      bus.wr = '0;
      bus.rd = 1'b0;
      if (t < 200) begin
        bus.wr = '1;
        bus.in = rep_row(16'(t));
        exp_q.push_back(rep_row(16'(t)));
      end
      if (t >= 3) begin
        exp_row = exp_q.pop_front();
        check($sformatf("wrap_out_%0d", t - 3), bus.out, exp_row);
        bus.rd = 1'b1;
      end
      step();
      check($sformatf("wrap_full_%0d", t), W'(bus.o_full), W'(0));
    end
    idle_inputs();
    check("wrap_empty", W'(bus.o_valid), W'(0));
    check("wrap_ovf", W'(bus.err_ovf), W'(0));
    check("wrap_udf", W'(bus.err_udf), W'(0));

    // Async reset with 10 rows buffered.
    bus.wr = '1;
    for (int r = 0; r < 10; r++) begin
      bus.in = mk_row(8'(8'h40 + r));
      step();
    end
    bus.wr = '0;
    check("pre_areset_head", bus.out, mk_row(8'h40));
    #2 reset = 1'b0;
    #1;
    check("areset_valid", W'(bus.o_valid), W'(0));
    check("areset_out", bus.out, '0);
    check("areset_ready", W'(bus.o_ready), W'(1));
    @(negedge clk);
    reset = 1'b1;
    step();
    bus.wr = '1;
    bus.in = rep_row(16'hbeef);
    step();
    bus.wr = '0;
    check("post_areset_out", bus.out, rep_row(16'hbeef));
    bus.rd = 1'b1;
    step();
    bus.rd = 1'b0;
    check("post_areset_empty", W'(bus.o_valid), W'(0));

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
